// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the memory port arbiter.
package mem_arb_pkg;

    // Default memory geometry, matching the single-port 64x4 memory
    localparam int DEFAULT_DEPTH      = 64;
    localparam int DEFAULT_WIDTH      = 4;
    localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_DEPTH);

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // One memory command at the default geometry
    typedef struct packed {
        logic                          wr_rd_en;
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_WIDTH-1:0]      wdata;
    } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_gnt_i, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_gnt_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan last_gnt+1 .. last_gnt+N modulo N, keep the first requester seen
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(last_gnt_i) + i) % N);
            if (!found && req_i[cand]) begin
                found      = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o  = cand;
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one single-port memory between NUM_REQ requesters.
//
// Handshake: a requester raises req_valid_i with a stable command and holds it
// until it sees its one-cycle req_ready_o pulse (with req_rdata_o/req_err_o);
// on the memory side mem_valid_o and the command stay stable until mem_ready_i
// is sampled high, or the watchdog gives up after TIMEOUT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 16,
    parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_en_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic                          req_err_o,
    output logic [IDX_W-1:0]              grant_id_o,
    output logic                          busy_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wdata_o,
    input  logic                          mem_ready_i,
    input  logic [WIDTH-1:0]              mem_rdata_i,
    output arb_state_e                    dbg_state_o
);

    // Watchdog counter never needs to exceed TIMEOUT; keep at least one bit
    localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic                    cmd_wr_q, cmd_wr_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [WIDTH-1:0]        cmd_wdata_q, cmd_wdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    busy_q, busy_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;
    logic [WIDTH-1:0]        rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i       (req_valid_i),
        .last_gnt_i  (last_gnt_q),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    // Next-state, command latch, watchdog and registered-output decode
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        grant_d     = grant_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        ready_d     = '0;
        rdata_d     = '0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d     = arb_idx;
                    last_gnt_d  = arb_idx;
                    cmd_wr_d    = |(arb_gnt & req_wr_rd_en_i);
                    cmd_addr_d  = req_addr_i[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_wdata_d = req_wdata_i[int'(arb_idx)*WIDTH +: WIDTH];
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // A late ready on the watchdog's last cycle still wins
                if (mem_ready_i) begin
                    state_d          = RESP;
                    ready_d[grant_q] = 1'b1;
                    if (!cmd_wr_q) begin
                        rdata_d = mem_rdata_i;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d          = RESP;
                    ready_d[grant_q] = 1'b1;
                    err_d            = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_valid_d = (state_d == BUSY);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset drops any transaction in flight silently
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            last_gnt_q  <= LAST_INIT;
            grant_q     <= '0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            grant_q     <= grant_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign req_rdata_o    = rdata_q;
    assign req_err_o      = err_q;
    assign grant_id_o     = grant_q;
    assign busy_o         = busy_q;
    assign mem_valid_o    = mem_valid_q;
    assign mem_wr_rd_en_o = cmd_wr_q;
    assign mem_addr_o     = cmd_addr_q;
    assign mem_wdata_o    = cmd_wdata_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: randomized batches against a round-robin service model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int WIDTH   = 4;
  localparam int AW      = 6;
  localparam int TIMEOUT = 16;
  localparam int IDX_W   = 2;
  localparam int EXP_W   = IDX_W + 1 + WIDTH;
  localparam int CMD_W   = 1 + AW + WIDTH;
  localparam int MAXJ    = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [NUM_REQ-1:0]    req_valid_i, req_wr_rd_en_i, req_ready_o;
  logic [NUM_REQ*AW-1:0] req_addr_i;
  logic [NUM_REQ*WIDTH-1:0] req_wdata_i;
  logic [WIDTH-1:0]      req_rdata_o, mem_wdata_o, mem_rdata_i;
  logic                  req_err_o, busy_o, mem_valid_o, mem_wr_rd_en_o, mem_ready_i;
  logic [IDX_W-1:0]      grant_id_o;
  logic [AW-1:0]         mem_addr_o;
  arb_state_e            dbg_state;

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .DEPTH(64), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_wr_rd_en_i(req_wr_rd_en_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .req_rdata_o(req_rdata_o), .req_err_o(req_err_o),
    .grant_id_o(grant_id_o), .busy_o(busy_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_en_o(mem_wr_rd_en_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];   // {requester, err, rdata} in expected service order
  logic [CMD_W-1:0] cmd_q[$];   // {wr, addr, wdata} expected on the memory bus
  int               lat_q[$];   // memory ready latency per transaction (> TIMEOUT: never)

  logic [WIDTH-1:0] ref_mem[64];  // reference model contents
  logic [WIDTH-1:0] mem_arr[64];  // memory stand-in contents
  int rr_ptr;

  int               b_cnt[NUM_REQ];
  logic             b_wr[NUM_REQ][MAXJ];
  logic [AW-1:0]    b_addr[NUM_REQ][MAXJ];
  logic [WIDTH-1:0] b_data[NUM_REQ][MAXJ];
  int               b_lat[NUM_REQ][MAXJ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Every requester with work left stays valid, so each grant goes to the
  // first requester after the previous winner that still has work.
  task automatic plan_batch();
    int rem[NUM_REQ];
    int pos[NUM_REQ];
    int left, pick, k, j;
    logic wr, err;
    logic [AW-1:0] a;
    logic [WIDTH-1:0] d, rd;
    left = 0;
    for (int n = 0; n < NUM_REQ; n++) begin
      rem[n] = b_cnt[n];
      pos[n] = 0;
      left += b_cnt[n];
    end
    while (left > 0) begin
      pick = -1;
      for (int i = 1; i <= NUM_REQ; i++) begin
        k = (rr_ptr + i) % NUM_REQ;
        if (pick < 0 && rem[k] > 0) pick = k;
      end
      rr_ptr = pick;
      j  = pos[pick];
      wr = b_wr[pick][j];
      a  = b_addr[pick][j];
      d  = b_data[pick][j];
      cmd_q.push_back({wr, a, d});
      lat_q.push_back(b_lat[pick][j]);
      if (b_lat[pick][j] <= TIMEOUT) begin
        err = 1'b0;
        if (wr) begin
          ref_mem[a] = d;
          rd = '0;
        end else begin
          rd = ref_mem[a];
        end
      end else begin
        err = 1'b1;
        rd  = '0;
      end
      exp_q.push_back({IDX_W'(pick), err, rd});
      pos[pick]++;
      rem[pick]--;
      left--;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_batch();
    for (int k = 0; k < NUM_REQ; k++) b_cnt[k] = 0;
  endtask

  task automatic set_txn(input int k, input int j, input logic wr, input int a, input int d, input int lat);
    b_wr[k][j]   = wr;
    b_addr[k][j] = AW'(a);
    b_data[k][j] = WIDTH'(d);
    b_lat[k][j]  = lat;
    if (b_cnt[k] < j + 1) b_cnt[k] = j + 1;
  endtask

  task automatic random_batch();
    int total, r;
    total = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      b_cnt[k] = $urandom_range(0, 3);
      total += b_cnt[k];
      for (int j = 0; j < MAXJ; j++) begin
        b_wr[k][j]   = 1'($urandom_range(0, 1));
        b_addr[k][j] = AW'($urandom_range(0, 7));
        b_data[k][j] = WIDTH'($urandom);
        r = $urandom_range(0, 9);
        b_lat[k][j]  = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT + 1 : $urandom_range(1, 4);
      end
    end
    if (total == 0) b_cnt[$urandom_range(0, NUM_REQ - 1)] = 1;
  endtask

  task automatic present(input int k, input int j);
    req_valid_i[k]                 = 1'b1;
    req_wr_rd_en_i[k]              = b_wr[k][j];
    req_addr_i[k*AW +: AW]         = b_addr[k][j];
    req_wdata_i[k*WIDTH +: WIDTH]  = b_data[k][j];
  endtask

  // Present the batch, re-presenting the next command right after each pulse
  task automatic run_batch();
    int pos[NUM_REQ];
    int pending, budget;
    plan_batch();
    pending = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos[k] = 0;
      pending += b_cnt[k];
      if (b_cnt[k] > 0) present(k, 0);
      else req_valid_i[k] = 1'b0;
    end
    budget = 0;
    while (pending > 0 && budget < 600) begin
      @(negedge clk_i);
      budget++;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_ready_o[k] && req_valid_i[k]) begin
          pos[k]++;
          pending--;
          if (pos[k] < b_cnt[k]) present(k, pos[k]);
          else req_valid_i[k] = 1'b0;
        end
      end
    end
    check("batch_complete", 32'(pending), 32'd0);
    if (pending > 0) req_valid_i = '0;
  endtask

  // ---------------- memory stand-in ----------------
  int c, lat_cur;
  logic active, rdy_set;
  logic [CMD_W-1:0] cur_cmd;

  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    active = 1'b0;
    rdy_set = 1'b0;
    c = 0;
    lat_cur = 0;
    cur_cmd = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        active = 1'b0;
        rdy_set = 1'b0;
        continue;
      end
      if (active && rdy_set) begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        check("valid_drop_after_ready", 32'(mem_valid_o), 32'd0);
        active = 1'b0;
        rdy_set = 1'b0;
        continue;
      end
      if (active && !mem_valid_o) begin
        check("valid_cycles", 32'(c), 32'((lat_cur > TIMEOUT) ? TIMEOUT : lat_cur));
        active = 1'b0;
        continue;
      end
      if (!active) begin
        if (!mem_valid_o) continue;
        active = 1'b1;
        c = 0;
        if (cmd_q.size() == 0 || lat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_mem_valid: got 1 expected 0 at %0t", $time);
          cur_cmd = {mem_wr_rd_en_o, mem_addr_o, mem_wdata_o};
          lat_cur = 1;
        end else begin
          cur_cmd = cmd_q.pop_front();
          lat_cur = lat_q.pop_front();
        end
      end
      c++;
      check("mem_cmd", 32'({mem_wr_rd_en_o, mem_addr_o, mem_wdata_o}), 32'(cur_cmd));
      if (c == lat_cur) begin
        mem_ready_i = 1'b1;
        if (mem_wr_rd_en_o) begin
          mem_arr[mem_addr_o] = mem_wdata_o;
          mem_rdata_i = WIDTH'($urandom_range(1, 15));
        end else begin
          mem_rdata_i = mem_arr[mem_addr_o];
        end
        rdy_set = 1'b1;
      end else if (c > TIMEOUT + 4) begin
        n_tests++;
        n_fail++;
        $display("FAIL watchdog_missing: got %0d busy cycles expected %0d", c, TIMEOUT);
        active = 1'b0;
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [EXP_W-1:0] e;
  logic [NUM_REQ-1:0] oh;
  logic prev_pulse;

  initial begin
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        prev_pulse = 1'b0;
        continue;
      end
      if (req_ready_o != '0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready: got %b expected 0", req_ready_o);
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e[EXP_W-1 -: IDX_W]] = 1'b1;
          check("ready_onehot", 32'(req_ready_o), 32'(oh));
          check("grant_id", 32'(grant_id_o), 32'(e[EXP_W-1 -: IDX_W]));
          check("resp_err", 32'(req_err_o), 32'(e[WIDTH]));
          check("resp_rdata", 32'(req_rdata_o), 32'(e[WIDTH-1:0]));
          check("resp_busy", 32'({busy_o, mem_valid_o}), 32'(2'b10));
        end
        prev_pulse = 1'b1;
      end else begin
        if (prev_pulse) begin
          check("resp_clear", 32'({req_err_o, req_rdata_o}), 32'd0);
        end
        prev_pulse = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_i          = 1'b0;
    req_valid_i    = '0;
    req_wr_rd_en_i = '0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    rr_ptr         = NUM_REQ - 1;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = '0;
      mem_arr[i] = '0;
    end
    repeat (3) @(negedge clk_i);
    check("reset_outputs", 32'({req_ready_o, req_err_o, req_rdata_o, grant_id_o, busy_o,
          mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(negedge clk_i);

    // single write from req0, ready after 2 cycles
    clear_batch();
    set_txn(0, 0, 1'b1, 5, 'hA, 2);
    run_batch();
    // single read from req1 of the same word
    clear_batch();
    set_txn(1, 0, 1'b0, 5, 0, 1);
    run_batch();
    // contention between req0 and req1, two transactions each
    clear_batch();
    set_txn(0, 0, 1'b1, 10, 'h1, 1);
    set_txn(0, 1, 1'b0, 10, 0, 2);
    set_txn(1, 0, 1'b1, 20, 'h2, 3);
    set_txn(1, 1, 1'b0, 20, 0, 1);
    run_batch();
    // watchdog expiry on a read
    clear_batch();
    set_txn(0, 0, 1'b0, 5, 0, TIMEOUT + 1);
    run_batch();
    // ready on the last watchdog cycle completes normally
    clear_batch();
    set_txn(0, 0, 1'b1, 7, 'h3, 1);
    set_txn(0, 1, 1'b0, 7, 0, TIMEOUT);
    run_batch();

    // reset while BUSY: silent drop, then req0 wins a tie
    req_valid_i[0]          = 1'b1;
    req_wr_rd_en_i[0]       = 1'b0;
    req_addr_i[0 +: AW]     = AW'(9);
    req_wdata_i[0 +: WIDTH] = '0;
    cmd_q.push_back({1'b0, AW'(9), WIDTH'(0)});
    lat_q.push_back(100);
    repeat (3) @(negedge clk_i);
    check("pre_reset_busy", 32'({busy_o, mem_valid_o}), 32'(2'b11));
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("midbusy_reset_outputs", 32'({req_ready_o, req_err_o, req_rdata_o, grant_id_o, busy_o,
          mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o}), 32'd0);
    req_valid_i = '0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    rr_ptr = NUM_REQ - 1;
    @(negedge clk_i);
    clear_batch();
    set_txn(0, 0, 1'b0, 7, 0, 1);
    set_txn(1, 0, 1'b0, 5, 0, 2);
    run_batch();

    // randomized batches
    for (int b = 0; b < 40; b++) begin
      random_batch();
      run_batch();
    end

    repeat (5) @(negedge clk_i);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound on the whole run
  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
